motor_steer_ctrl: RTL and testbench
===================================

// Module: motor_steer_ctrl
// PURPOSE
//  Consumer end of the camera detector's operate_mode interface. Debounces the
//  3-bit steering decision, runs a motion FSM (idle/scan/forward/turn) and drives
//  two wheel H-bridges with direction bits and glitch-free PWM.
//  Sits between the colour-detect stage and the motor driver pins.
// PARAMETERS
//  PWM_PERIOD      1000   PWM period in clk cycles (>=2)
//  DUTY_FWD        700    high cycles per period in FORWARD (<=PWM_PERIOD)
//  DUTY_TURN       500    high cycles per period in TURN_LEFT/TURN_RIGHT
//  DUTY_SCAN       400    high cycles per period in SCAN
//  CONFIRM_CYCLES  8      consecutive equal samples needed to accept a new mode (>=1)
//  LOST_TIMEOUT    50000  NO_COLOR cycles tolerated in FORWARD/TURN before SCAN (>=1)
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  enable        in   1  1 = run; 0 = force IDLE, motors off
//  operate_mode  in   3  100 LEFT, 010 MIDDLE, 001 RIGHT, 000 NO_COLOR
//  left_pwm      out  1  left wheel PWM
//  right_pwm     out  1  right wheel PWM
//  left_dir      out  1  left wheel direction, 1 = forward
//  right_dir     out  1  right wheel direction, 1 = forward
//  motion_state  out  3  0 IDLE, 1 SCAN, 2 FORWARD, 3 TURN_LEFT, 4 TURN_RIGHT
// BEHAVIOUR
//  Reset: motion_state=IDLE, pwm/dir outputs 0, confirmed mode NO_COLOR, all counters 0.
//  Mode decode: any operate_mode value other than the four legal codes is NO_COLOR.
//  Debounce: candidate reg + count. Sample != candidate -> candidate<=sample, count<=1.
//   Sample == candidate -> count saturates at CONFIRM_CYCLES.
//   confirmed<=candidate on the edge where count reaches CONFIRM_CYCLES.
//   A mode held from edge t is confirmed at edge t+CONFIRM_CYCLES-1.
//   With CONFIRM_CYCLES=1, confirmation happens on the same edge.
//  FSM: one register. Transitions evaluate on the confirmed mode, so state changes
//   one edge after confirmation. Priority order: reset > enable==0 > other rules.
//   IDLE: enable==1 -> SCAN.
//   SCAN: LEFT->TURN_LEFT, MIDDLE->FORWARD, RIGHT->TURN_RIGHT; NO_COLOR stays.
//   FORWARD/TURN_*: LEFT/MIDDLE/RIGHT select TURN_LEFT/FORWARD/TURN_RIGHT.
//    NO_COLOR keeps the state and increments lost_cnt.
//    lost_cnt==LOST_TIMEOUT-1 while still NO_COLOR -> SCAN; lost_cnt<=0.
//    Any non-NO_COLOR confirmed mode, or entry to SCAN/IDLE, clears lost_cnt.
//  Drive targets (duty, ldir, rdir):
//   IDLE 0,0,0; SCAN DUTY_SCAN,1,0 (spin right); FORWARD DUTY_FWD,1,1;
//   TURN_LEFT DUTY_TURN,0,1; TURN_RIGHT DUTY_TURN,1,0.
//  PWM: pwm_cnt is free-running 0..PWM_PERIOD-1 and wraps to 0.
//   Active duty and dir are latched from the targets on the edge where
//   pwm_cnt==PWM_PERIOD-1, so updates apply only at period boundaries (no runt pulses).
//   Both pwm outputs = (pwm_cnt < active_duty), registered.
//   Exception: state==IDLE forces pwm=0 and dir=0 on the next edge without waiting
//   for a wrap, and the active duty/dir latches clear.
//  Widths: counters are $clog2(param+1) bits; no overflow (saturate/wrap as stated).
//  Reset mid-operation: all state returns to reset values on the next edge.
// TESTING (PWM_PERIOD=10 DUTY_FWD=7 DUTY_TURN=5 DUTY_SCAN=4 CONFIRM_CYCLES=4 LOST_TIMEOUT=20)
//  1 Reset 3 cycles, enable=0 -> all outputs 0, motion_state=0.
//    Then enable=1 -> motion_state=1 next edge; after the next wrap left_dir=1,
//    right_dir=0, and left_pwm is high 4 of 10 cycles.
//  2 In SCAN, hold operate_mode=010 -> confirmed on the 4th edge, motion_state=2 one
//    edge later; from the following period both dir=1 and both pwm are high 7/10.
//  3 In FORWARD, operate_mode=100 for 3 cycles then back to 010 -> motion_state stays 2;
//    holding 100 >=4 cycles -> motion_state=3, left_dir=0, right_dir=1, duty 5/10.
//  4 In FORWARD, 000 for 19 confirmed cycles then 010 -> stays 2. Holding 000 long
//    enough (3 debounce edges + 20 NO_COLOR cycles) -> motion_state=1, scan drive.
//  5 Drop enable mid-period in FORWARD -> next edge motion_state=0 and pwm/dir=0
//    without waiting for a wrap. Also: operate_mode=110 behaves exactly as 000.
//  6 Assert reset during TURN_RIGHT with pwm high -> next edge all outputs 0, IDLE;
//    after release, a held mode needs the full 4-cycle confirmation again.

Source files
------------

// File: rtl/motor_steer_ctrl.sv
// Steering consumer: debounces operate_mode, runs the motion FSM
// and drives both wheel H-bridges with period-aligned PWM.
module motor_steer_ctrl #(
   parameter int PWM_PERIOD     = 1000,
   parameter int DUTY_FWD       = 700,
   parameter int DUTY_TURN      = 500,
   parameter int DUTY_SCAN      = 400,
   parameter int CONFIRM_CYCLES = 8,
   parameter int LOST_TIMEOUT   = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] operate_mode,
   output logic       left_pwm,
   output logic       right_pwm,
   output logic       left_dir,
   output logic       right_dir,
   output logic [2:0] motion_state
);

   localparam int PW = $clog2(PWM_PERIOD + 1);
   localparam int CW = $clog2(CONFIRM_CYCLES + 1);
   localparam int LW = $clog2(LOST_TIMEOUT + 1);

   localparam logic [2:0] M_NONE  = 3'b000;
   localparam logic [2:0] M_LEFT  = 3'b100;
   localparam logic [2:0] M_MID   = 3'b010;
   localparam logic [2:0] M_RIGHT = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_FWD   = 3'd2,
      S_TLEFT = 3'd3,
      S_TRGHT = 3'd4
   } state_t;

   logic [2:0]    mode_s;
   logic [2:0]    cand_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    conf_q;
   state_t        state_q;
   state_t        sel_d;
   logic [LW-1:0] lost_q;
   logic [PW-1:0] pwm_cnt_q;
   logic [PW-1:0] pwm_cnt_d;
   logic [PW-1:0] duty_q;
   logic [PW-1:0] duty_d;
   logic [PW-1:0] tgt_duty;
   logic          tgt_ldir;
   logic          tgt_rdir;
   logic          ldir_q;
   logic          ldir_d;
   logic          rdir_q;
   logic          rdir_d;
   logic          pwm_q;
   logic          wrap;

   // Illegal codes collapse onto NO_COLOR
   always_comb begin
      mode_s = M_NONE;
      if (operate_mode == M_LEFT || operate_mode == M_MID ||
          operate_mode == M_RIGHT)
         mode_s = operate_mode;
   end

   // Debounce: a mode must repeat CONFIRM_CYCLES samples to be confirmed
   always_ff @(posedge clk) begin
      if (reset) begin
         cand_q <= M_NONE;
         cnt_q  <= '0;
         conf_q <= M_NONE;
      end else if (mode_s != cand_q) begin
         cand_q <= mode_s;
         cnt_q  <= CW'(1);
         if (CONFIRM_CYCLES == 1)
            conf_q <= mode_s;
      end else if (cnt_q < CW'(CONFIRM_CYCLES)) begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CW'(CONFIRM_CYCLES - 1))
            conf_q <= cand_q;
      end
   end

   // Steering target chosen by a confirmed colour
   always_comb begin
      sel_d = S_FWD;
      unique case (conf_q)
         M_LEFT:  sel_d = S_TLEFT;
         M_RIGHT: sel_d = S_TRGHT;
         default: sel_d = S_FWD;
      endcase
   end

   // Motion FSM with NO_COLOR timeout back to SCAN
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         lost_q  <= '0;
      end else if (!enable) begin
         state_q <= S_IDLE;
         lost_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_q <= S_SCAN;
               lost_q  <= '0;
            end
            S_SCAN: begin
               lost_q <= '0;
               if (conf_q != M_NONE)
                  state_q <= sel_d;
            end
            default: begin
               if (conf_q != M_NONE) begin
                  state_q <= sel_d;
                  lost_q  <= '0;
               end else if (lost_q == LW'(LOST_TIMEOUT - 1)) begin
                  state_q <= S_SCAN;
                  lost_q  <= '0;
               end else begin
                  lost_q <= lost_q + 1'b1;
               end
            end
         endcase
      end
   end

   // Drive target per motion state
   always_comb begin
      tgt_duty = '0;
      tgt_ldir = 1'b0;
      tgt_rdir = 1'b0;
      unique case (state_q)
         S_SCAN: begin
            tgt_duty = PW'(DUTY_SCAN);
            tgt_ldir = 1'b1;
         end
         S_FWD: begin
            tgt_duty = PW'(DUTY_FWD);
            tgt_ldir = 1'b1;
            tgt_rdir = 1'b1;
         end
         S_TLEFT: begin
            tgt_duty = PW'(DUTY_TURN);
            tgt_rdir = 1'b1;
         end
         S_TRGHT: begin
            tgt_duty = PW'(DUTY_TURN);
            tgt_ldir = 1'b1;
         end
         default: tgt_duty = '0;
      endcase
   end

   assign wrap      = (pwm_cnt_q == PW'(PWM_PERIOD - 1));
   assign pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 1'b1;

   // Latch targets at period boundary; going IDLE clears at once
   always_comb begin
      duty_d = duty_q;
      ldir_d = ldir_q;
      rdir_d = rdir_q;
      if (wrap) begin
         duty_d = tgt_duty;
         ldir_d = tgt_ldir;
         rdir_d = tgt_rdir;
      end
      if (!enable) begin
         duty_d = '0;
         ldir_d = 1'b0;
         rdir_d = 1'b0;
      end
   end

   // PWM counter, active latches and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         ldir_q    <= 1'b0;
         rdir_q    <= 1'b0;
         pwm_q     <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         ldir_q    <= ldir_d;
         rdir_q    <= rdir_d;
         pwm_q     <= (pwm_cnt_d < duty_d);
      end
   end

   assign left_pwm     = pwm_q;
   assign right_pwm    = pwm_q;
   assign left_dir     = ldir_q;
   assign right_dir    = rdir_q;
   assign motion_state = state_q;

endmodule

// File: tb/tb_motor_steer_ctrl.sv
// Bench for motor_steer_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_motor_steer_ctrl;

   localparam int P  = 10;
   localparam int DF = 7;
   localparam int DT = 5;
   localparam int DS = 4;
   localparam int C  = 4;
   localparam int LT = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [2:0] operate_mode = 3'b000;
   logic       left_pwm;
   logic       right_pwm;
   logic       left_dir;
   logic       right_dir;
   logic [2:0] motion_state;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic [2:0] rv = 0;
   int         rl = 0;
   logic [2:0] conf = 0;
   int         st = 0;
   int         lost = 0;
   int         ncyc = 0;
   int         duty = 0;
   logic       ld = 0;
   logic       rd = 0;
   logic       pwm = 0;

   motor_steer_ctrl #(
      .PWM_PERIOD(P), .DUTY_FWD(DF), .DUTY_TURN(DT),
      .DUTY_SCAN(DS), .CONFIRM_CYCLES(C), .LOST_TIMEOUT(LT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .operate_mode(operate_mode),
      .left_pwm(left_pwm),
      .right_pwm(right_pwm),
      .left_dir(left_dir),
      .right_dir(right_dir),
      .motion_state(motion_state)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] decode(input logic [2:0] m);
      if (m == 3'b100 || m == 3'b010 || m == 3'b001) return m;
      return 3'b000;
   endfunction

   function automatic int pick(input logic [2:0] m);
      if (m == 3'b100) return 3;
      if (m == 3'b001) return 4;
      return 2;
   endfunction

   function automatic logic [6:0] obs();
      return {motion_state, left_dir, right_dir, left_pwm, right_pwm};
   endfunction

   function automatic logic [6:0] expv();
      logic [2:0] s;
      s = 3'(st);
      return {s, ld, rd, pwm, pwm};
   endfunction

   task automatic model_step();
      logic [2:0] m;
      int nst;
      m = decode(operate_mode);
      if (reset) begin
         rv = 0; rl = 0; conf = 0; st = 0; lost = 0;
         ncyc = 0; duty = 0; ld = 0; rd = 0; pwm = 0;
         return;
      end
      if (ncyc % P == P - 1) begin
         case (st)
            1: begin duty = DS; ld = 1; rd = 0; end
            2: begin duty = DF; ld = 1; rd = 1; end
            3: begin duty = DT; ld = 0; rd = 1; end
            4: begin duty = DT; ld = 1; rd = 0; end
            default: begin duty = 0; ld = 0; rd = 0; end
         endcase
      end
      ncyc++;
      nst = st;
      if (!enable) begin
         nst = 0; lost = 0;
      end else if (st == 0) begin
         nst = 1; lost = 0;
      end else if (st == 1) begin
         lost = 0;
         if (conf != 0) nst = pick(conf);
      end else if (conf != 0) begin
         nst = pick(conf); lost = 0;
      end else if (lost == LT - 1) begin
         nst = 1; lost = 0;
      end else begin
         lost++;
      end
      if (m == rv) begin
         if (rl < C) rl++;
      end else begin
         rv = m; rl = 1;
      end
      if (rl == C) conf = rv;
      st = nst;
      if (st == 0) begin
         duty = 0; ld = 0; rd = 0;
      end
      pwm = ((ncyc % P) < duty);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1; enable = 0; operate_mode = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if (obs() !== 7'd0) begin
            n_err++;
            $display("FAIL reset_outs cyc %0d got %h exp 00", i, obs());
         end
      end
   endtask

   task automatic test_scan();
      int hi;
      reset = 0;
      cyc();
      enable = 1;
      cyc();
      n_cmp++;
      if (motion_state !== 3'd1) begin
         n_err++;
         $display("FAIL scan_entry got %0d exp 1", motion_state);
      end
      for (int i = 0; i < 25; i++) begin
         cyc();
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL scan_model got %h exp %h", obs(), expv());
         end
      end
      hi = 0;
      for (int i = 0; i < P; i++) begin
         cyc();
         hi += int'(left_pwm);
      end
      n_cmp++;
      if (hi != DS || left_dir !== 1'b1 || right_dir !== 1'b0) begin
         n_err++;
         $display("FAIL scan_drive got hi=%0d dir=%b%b exp hi=%0d dir=10",
                  hi, left_dir, right_dir, DS);
      end
   endtask

   task automatic test_forward();
      int hi;
      operate_mode = 3'b010;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (i == 3) begin
            n_cmp++;
            if (motion_state !== 3'd1) begin
               n_err++;
               $display("FAIL fwd_confirm_edge got %0d exp 1", motion_state);
            end
         end
      end
      n_cmp++;
      if (motion_state !== 3'd2) begin
         n_err++;
         $display("FAIL fwd_entry got %0d exp 2", motion_state);
      end
      for (int i = 0; i < 25; i++) begin
         cyc();
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL fwd_model got %h exp %h", obs(), expv());
         end
      end
      hi = 0;
      for (int i = 0; i < P; i++) begin
         cyc();
         hi += int'(right_pwm);
      end
      n_cmp++;
      if (hi != DF || left_dir !== 1'b1 || right_dir !== 1'b1) begin
         n_err++;
         $display("FAIL fwd_drive got hi=%0d dir=%b%b exp hi=%0d dir=11",
                  hi, left_dir, right_dir, DF);
      end
   endtask

   task automatic test_glitch();
      int hi;
      operate_mode = 3'b100;
      repeat (3) cyc();
      operate_mode = 3'b010;
      repeat (10) cyc();
      n_cmp++;
      if (motion_state !== 3'd2) begin
         n_err++;
         $display("FAIL glitch_hold got %0d exp 2", motion_state);
      end
      operate_mode = 3'b100;
      for (int i = 0; i < 25; i++) begin
         cyc();
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL tleft_model got %h exp %h", obs(), expv());
         end
      end
      hi = 0;
      for (int i = 0; i < P; i++) begin
         cyc();
         hi += int'(left_pwm);
      end
      n_cmp++;
      if (motion_state !== 3'd3 || hi != DT ||
          left_dir !== 1'b0 || right_dir !== 1'b1) begin
         n_err++;
         $display("FAIL tleft_drive got st=%0d hi=%0d dir=%b%b exp st=3 hi=%0d dir=01",
                  motion_state, hi, left_dir, right_dir, DT);
      end
   endtask

   task automatic test_lost(input logic [2:0] none_code, input string nm);
      int hi;
      operate_mode = 3'b010;
      repeat (25) cyc();
      operate_mode = none_code;
      repeat (19) cyc();
      operate_mode = 3'b010;
      repeat (10) cyc();
      n_cmp++;
      if (motion_state !== 3'd2) begin
         n_err++;
         $display("FAIL %s_short got %0d exp 2", nm, motion_state);
      end
      operate_mode = none_code;
      for (int i = 0; i < 40; i++) begin
         cyc();
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL %s_model got %h exp %h", nm, obs(), expv());
         end
      end
      hi = 0;
      for (int i = 0; i < P; i++) begin
         cyc();
         hi += int'(left_pwm);
      end
      n_cmp++;
      if (motion_state !== 3'd1 || hi != DS ||
          left_dir !== 1'b1 || right_dir !== 1'b0) begin
         n_err++;
         $display("FAIL %s_scan got st=%0d hi=%0d dir=%b%b exp st=1 hi=%0d dir=10",
                  nm, motion_state, hi, left_dir, right_dir, DS);
      end
   endtask

   task automatic test_enable_drop();
      operate_mode = 3'b010;
      repeat (25) cyc();
      for (int i = 0; i < P && (ncyc % P) != 3; i++) cyc();
      enable = 0;
      cyc();
      n_cmp++;
      if (obs() !== 7'd0) begin
         n_err++;
         $display("FAIL enable_drop got %h exp 00", obs());
      end
      enable = 1;
   endtask

   task automatic test_reset_mid();
      bit seen;
      operate_mode = 3'b001;
      repeat (25) cyc();
      seen = 0;
      for (int i = 0; i < 2 * P && !seen; i++) begin
         if (left_pwm === 1'b1 && motion_state === 3'd4) seen = 1;
         else cyc();
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL tright_wait got st=%0d pwm=%b exp st=4 pwm=1",
                  motion_state, left_pwm);
      end
      reset = 1;
      cyc();
      n_cmp++;
      if (obs() !== 7'd0) begin
         n_err++;
         $display("FAIL reset_mid got %h exp 00", obs());
      end
      reset = 0;
      for (int i = 0; i < 4; i++) cyc();
      n_cmp++;
      if (motion_state !== 3'd1) begin
         n_err++;
         $display("FAIL reconfirm_early got %0d exp 1", motion_state);
      end
      cyc();
      n_cmp++;
      if (motion_state !== 3'd4) begin
         n_err++;
         $display("FAIL reconfirm got %0d exp 4", motion_state);
      end
   endtask

   task automatic test_random();
      int len;
      int r;
      logic [2:0] m;
      for (int seg = 0; seg < 250; seg++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1: m = 3'b000;
            2, 3: m = 3'b100;
            4, 5: m = 3'b010;
            6, 7: m = 3'b001;
            default: m = 3'($urandom);
         endcase
         operate_mode = m;
         enable = ($urandom_range(0, 29) != 0);
         reset = ($urandom_range(0, 59) == 0);
         len = int'($urandom_range(1, (r < 2) ? 30 : 8));
         for (int i = 0; i < len; i++) begin
            cyc();
            reset = 0;
            enable = enable | ($urandom_range(0, 2) == 0);
            n_cmp++;
            if (obs() !== expv()) begin
               n_err++;
               $display("FAIL rand_model seg %0d got %h exp %h",
                        seg, obs(), expv());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_forward();
      test_glitch();
      test_lost(3'b000, "lost");
      test_lost(3'b110, "illegal");
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
